// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera frame packer.
package cam_pkg;

    typedef enum logic [1:0] {
        stIdle,
        stArmed,
        stCapture,
        stFlush
    } cam_state_e;

    localparam logic [7:0] HDR_MARK_DEFAULT = 8'hA5;

    // Smallest n such that 2**n >= value.
    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered output stage; capacity (memory plus output
// register) is DEPTH words.
module sync_fifo
    import cam_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = log2_ceil(DEPTH);
    localparam int unsigned CW = log2_ceil(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d, total_cnt;
    logic [DW-1:0] out_q;
    logic          out_vld_q, out_vld_d;
    logic          rd_fire, wr_fire, load_out;

    always_comb begin
        total_cnt = mem_cnt_q + CW'(out_vld_q);
        full_o    = (total_cnt == CW'(DEPTH));
        empty_o   = (total_cnt == '0);
        rd_fire   = rd_en_i & out_vld_q;
        // A pop frees a slot in the same cycle, so a write while full still lands.
        wr_fire   = wr_en_i & (~full_o | rd_fire);
        load_out  = (mem_cnt_q != '0) & (~out_vld_q | rd_fire);
        mem_cnt_d = mem_cnt_q + CW'(wr_fire) - CW'(load_out);
        out_vld_d = load_out | (out_vld_q & ~rd_fire);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load_out) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                out_q    <= mem_q[rd_ptr_q];
            end
            mem_cnt_q <= mem_cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = out_q;
    assign rd_valid_o = out_vld_q;

endmodule

// File: rtl/cam_frame_packer.sv
// Captures whole camera frames, prefixes a header word, checks geometry and
// serializes the buffered words high byte first onto a valid/ready byte stream.
module cam_frame_packer
    import cam_pkg::*;
#(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  HDR_MARK   = HDR_MARK_DEFAULT
) (
    input  logic        CLK,
    input  logic        SRST,
    input  logic [15:0] PIX_D_I,
    input  logic        PIX_DV_I,
    input  logic        LV_I,
    input  logic        FV_I,
    input  logic        CAPT_I,
    input  logic        CONT_I,
    output logic [7:0]  OUT_D_O,
    output logic        OUT_VALID_O,
    input  logic        OUT_READY_I,
    output logic        BUSY_O,
    output logic [7:0]  FRAME_CNT_O,
    output logic        OVF_O,
    output logic        SIZE_ERR_O
);

    localparam int unsigned COL_W  = log2_ceil(WIDTH + 1);
    localparam int unsigned LINE_W = log2_ceil(HEIGHT + 1);

    cam_state_e        state_q, state_d;
    logic              fv_q, lv_q;
    logic              fv_rise, fv_fall, lv_fall;
    logic [COL_W-1:0]  col_q, col_d, col_eff;
    logic [LINE_W-1:0] line_q, line_d, line_eff;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              ovf_q, ovf_d;
    logic              size_err_q, size_err_d;
    logic              drop_q, drop_d;

    logic              fifo_wr_en, fifo_rd_en, fifo_rd_valid, fifo_full, fifo_empty;
    logic [15:0]       fifo_wr_data, fifo_rd_data;

    logic [15:0]       ser_word_q;
    logic              ser_vld_q, byte_sel_q;
    logic              out_fire, ser_load;

    assign fv_rise = FV_I & ~fv_q;
    assign fv_fall = ~FV_I & fv_q;
    assign lv_fall = ~LV_I & lv_q;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        line_d       = line_q;
        frame_cnt_d  = frame_cnt_q;
        ovf_d        = ovf_q;
        size_err_d   = size_err_q;
        drop_d       = drop_q;
        col_eff      = col_q;
        line_eff     = line_q;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = PIX_D_I;

        unique case (state_q)
            stIdle: begin
                if (CAPT_I || CONT_I) begin
                    state_d    = stArmed;
                    ovf_d      = 1'b0;
                    size_err_d = 1'b0;
                end
            end
            stArmed: begin
                if (fv_rise) begin
                    state_d      = stCapture;
                    fifo_wr_en   = 1'b1;
                    fifo_wr_data = {HDR_MARK, frame_cnt_q};
                    col_d        = '0;
                    line_d       = '0;
                    drop_d       = 1'b0;
                    // The header owns this cycle's write slot; a pixel here is lost.
                    if (PIX_DV_I) begin
                        size_err_d = 1'b1;
                    end
                end
            end
            stCapture: begin
                if (PIX_DV_I) begin
                    fifo_wr_en = ~drop_q;
                    col_eff    = (&col_q) ? col_q : col_q + COL_W'(1);
                end
                col_d = col_eff;
                if (lv_fall) begin
                    if (col_eff != COL_W'(WIDTH)) begin
                        size_err_d = 1'b1;
                    end
                    col_d    = '0;
                    line_eff = (&line_q) ? line_q : line_q + LINE_W'(1);
                end
                line_d = line_eff;
                if (fv_fall) begin
                    if (line_eff != LINE_W'(HEIGHT)) begin
                        size_err_d = 1'b1;
                    end
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = stFlush;
                end
            end
            stFlush: begin
                if (fifo_empty && !ser_vld_q) begin
                    state_d = CONT_I ? stArmed : stIdle;
                end
            end
            default: state_d = stIdle;
        endcase

        // Once a word is lost the rest of the frame is dropped to keep the stream aligned.
        if (fifo_wr_en && fifo_full && !fifo_rd_en) begin
            ovf_d  = 1'b1;
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            state_q     <= stIdle;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            col_q       <= '0;
            line_q      <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            size_err_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fv_q        <= FV_I;
            lv_q        <= LV_I;
            col_q       <= col_d;
            line_q      <= line_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            size_err_q  <= size_err_d;
            drop_q      <= drop_d;
        end
    end

    sync_fifo #(
        .DW    (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .srst_i     (SRST),
        .wr_en_i    (fifo_wr_en),
        .wr_data_i  (fifo_wr_data),
        .rd_en_i    (fifo_rd_en),
        .rd_data_o  (fifo_rd_data),
        .rd_valid_o (fifo_rd_valid),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Reload on the same edge the low byte is taken so the stream has no bubble.
    assign out_fire   = ser_vld_q & OUT_READY_I;
    assign ser_load   = fifo_rd_valid & (~ser_vld_q | (out_fire & byte_sel_q));
    assign fifo_rd_en = ser_load;

    always_ff @(posedge CLK) begin
        if (SRST) begin
            ser_word_q <= '0;
            ser_vld_q  <= 1'b0;
            byte_sel_q <= 1'b0;
        end else if (ser_load) begin
            ser_word_q <= fifo_rd_data;
            ser_vld_q  <= 1'b1;
            byte_sel_q <= 1'b0;
        end else if (out_fire) begin
            if (!byte_sel_q) begin
                byte_sel_q <= 1'b1;
            end else begin
                ser_vld_q  <= 1'b0;
                byte_sel_q <= 1'b0;
            end
        end
    end

    assign OUT_D_O     = byte_sel_q ? ser_word_q[7:0] : ser_word_q[15:8];
    assign OUT_VALID_O = ser_vld_q;
    assign BUSY_O      = (state_q != stIdle);
    assign FRAME_CNT_O = frame_cnt_q;
    assign OVF_O       = ovf_q;
    assign SIZE_ERR_O  = size_err_q;

endmodule

// File: tb/tb_cam_frame_packer.sv
// Directed-plus-random bench for cam_frame_packer with a queue-based byte-stream model.
module tb_cam_frame_packer;

    localparam int unsigned W   = 4;
    localparam int unsigned H   = 2;
    localparam int unsigned D   = 4;
    localparam logic [7:0]  HDR = 8'hA5;

    logic        CLK = 1'b0;
    logic        SRST = 1'b1;
    logic [15:0] PIX_D_I = '0;
    logic        PIX_DV_I = 1'b0;
    logic        LV_I = 1'b0;
    logic        FV_I = 1'b0;
    logic        CAPT_I = 1'b0;
    logic        CONT_I = 1'b0;
    logic [7:0]  OUT_D_O;
    logic        OUT_VALID_O;
    logic        OUT_READY_I = 1'b0;
    logic        BUSY_O;
    logic [7:0]  FRAME_CNT_O;
    logic        OVF_O;
    logic        SIZE_ERR_O;

    always #5 CLK = ~CLK;

    cam_frame_packer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (D),
        .HDR_MARK   (HDR)
    ) dut (
        .CLK         (CLK),
        .SRST        (SRST),
        .PIX_D_I     (PIX_D_I),
        .PIX_DV_I    (PIX_DV_I),
        .LV_I        (LV_I),
        .FV_I        (FV_I),
        .CAPT_I      (CAPT_I),
        .CONT_I      (CONT_I),
        .OUT_D_O     (OUT_D_O),
        .OUT_VALID_O (OUT_VALID_O),
        .OUT_READY_I (OUT_READY_I),
        .BUSY_O      (BUSY_O),
        .FRAME_CNT_O (FRAME_CNT_O),
        .OVF_O       (OVF_O),
        .SIZE_ERR_O  (SIZE_ERR_O)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          rdy_mode = 1;
    int unsigned cyc = 0;
    int          exp_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [15:0] sent_q[$];
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_d = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Sink ready pattern: 0 = stalled, 1 = always ready, 2 = ready one cycle in three.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       OUT_READY_I = 1'b0;
                2:       OUT_READY_I = (cyc % 3 == 0);
                default: OUT_READY_I = 1'b1;
            endcase
            cyc++;
        end
    end

    // Collect accepted bytes and check the byte is held while the sink stalls.
    always @(negedge CLK) begin
        if (prev_hold && !SRST) begin
            n_checks++;
            assert (OUT_VALID_O === 1'b1 && OUT_D_O === prev_d) else begin
                n_fail++;
                $error("FAIL hold: observed valid=%0b data=%0h expected valid=1 data=%0h",
                       OUT_VALID_O, OUT_D_O, prev_d);
            end
        end
        if (OUT_VALID_O === 1'b1 && OUT_READY_I === 1'b1 && !SRST) begin
            got_q.push_back(OUT_D_O);
        end
        prev_hold = (OUT_VALID_O === 1'b1) && (OUT_READY_I === 1'b0) && !SRST;
        prev_d    = OUT_D_O;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Two-line frame; pixels are a fixed ramp (seq) or random, and are logged in sent_q.
    task automatic send_frame(input int npl0, input int npl1, input int gap, input bit seq,
                              input bit lat, input bit drop_cont);
        int k;
        k = 0;
        FV_I = 1'b1;
        step(1);
        if (lat) chk("lat_edge1_valid", OUT_VALID_O, 0);
        if (drop_cont) CONT_I = 1'b0;
        step(1);
        if (lat) chk("lat_edge2_valid", OUT_VALID_O, 0);
        step(1);
        if (lat) begin
            chk("lat_edge3_valid", OUT_VALID_O, 1);
            chk("lat_edge3_hdr", OUT_D_O, HDR);
        end
        for (int ln = 0; ln < 2; ln++) begin
            int npl;
            npl = (ln == 0) ? npl0 : npl1;
            LV_I = 1'b1;
            for (int p = 0; p < npl; p++) begin
                logic [15:0] px;
                px = seq ? {8'(2 * k + 1), 8'(2 * k + 2)} : 16'($urandom);
                PIX_D_I  = px;
                PIX_DV_I = 1'b1;
                sent_q.push_back(px);
                k++;
                step(1);
                PIX_DV_I = 1'b0;
                if (gap > 1) step(gap - 1);
            end
            LV_I = 1'b0;
            step(3);
        end
        FV_I = 1'b0;
        step(2);
    endtask

    // Expected stream of one captured frame: header, then the first `keep` pixel words.
    task automatic model_frame(input int keep);
        exp_q.push_back(HDR);
        exp_q.push_back(8'(exp_cnt));
        for (int i = 0; i < sent_q.size() && i < keep; i++) begin
            exp_q.push_back(sent_q[i][15:8]);
            exp_q.push_back(sent_q[i][7:0]);
        end
        sent_q.delete();
        exp_cnt++;
    endtask

    task automatic compare_stream(input string tag);
        chk($sformatf("%s_len", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && BUSY_O !== 1'b0; i++) begin
            step(1);
        end
        step(2);
        chk("idle_reached", BUSY_O, 0);
    endtask

    task automatic capt_pulse();
        CAPT_I = 1'b1;
        step(1);
        CAPT_I = 1'b0;
    endtask

    initial begin
        step(3);
        SRST = 1'b0;
        step(1);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_valid", OUT_VALID_O, 0);
        chk("rst_data", OUT_D_O, 0);
        chk("rst_cnt", FRAME_CNT_O, 0);
        chk("rst_ovf", OVF_O, 0);
        chk("rst_size", SIZE_ERR_O, 0);

        // Ramp frame, sink always ready, header latency checked.
        capt_pulse();
        chk("t1_busy", BUSY_O, 1);
        send_frame(W, W, 1, 1'b1, 1'b1, 1'b0);
        model_frame(1000);
        wait_idle(300);
        compare_stream("t1");
        chk("t1_cnt", FRAME_CNT_O, 8'(exp_cnt));
        chk("t1_ovf", OVF_O, 0);
        chk("t1_size", SIZE_ERR_O, 0);

        // Random pixels, sink ready one cycle in three.
        rdy_mode = 2;
        capt_pulse();
        send_frame(W, W, 8, 1'b0, 1'b0, 1'b0);
        model_frame(1000);
        wait_idle(800);
        compare_stream("t2");
        chk("t2_cnt", FRAME_CNT_O, 8'(exp_cnt));
        rdy_mode = 1;
        step(2);

        // Stalled sink: only header plus FIFO-depth pixels survive.
        rdy_mode = 0;
        step(1);
        capt_pulse();
        send_frame(W, W, 1, 1'b0, 1'b0, 1'b0);
        model_frame(D);
        chk("t3_ovf", OVF_O, 1);
        chk("t3_cnt", FRAME_CNT_O, 8'(exp_cnt));
        chk("t3_busy_stalled", BUSY_O, 1);
        chk("t3_size", SIZE_ERR_O, 0);
        rdy_mode = 1;
        wait_idle(300);
        compare_stream("t3");

        // Short first line flags a geometry error; the next capture request clears it.
        capt_pulse();
        chk("t4_ovf_cleared", OVF_O, 0);
        chk("t4_size_pre", SIZE_ERR_O, 0);
        send_frame(W - 1, W, 1, 1'b0, 1'b0, 1'b0);
        model_frame(1000);
        chk("t4_size_set", SIZE_ERR_O, 1);
        wait_idle(300);
        compare_stream("t4");
        chk("t4_size_sticky", SIZE_ERR_O, 1);
        capt_pulse();
        chk("t4_size_cleared", SIZE_ERR_O, 0);
        chk("t4_busy_armed", BUSY_O, 1);

        // Reset in the middle of a line.
        FV_I = 1'b1;
        step(3);
        LV_I = 1'b1;
        PIX_DV_I = 1'b1;
        PIX_D_I = 16'($urandom);
        step(2);
        SRST = 1'b1;
        step(1);
        SRST = 1'b0;
        FV_I = 1'b0;
        LV_I = 1'b0;
        PIX_DV_I = 1'b0;
        chk("t5_busy", BUSY_O, 0);
        chk("t5_valid", OUT_VALID_O, 0);
        chk("t5_data", OUT_D_O, 0);
        chk("t5_cnt", FRAME_CNT_O, 0);
        chk("t5_ovf", OVF_O, 0);
        chk("t5_size", SIZE_ERR_O, 0);
        step(4);
        chk("t5_fifo_empty", OUT_VALID_O, 0);
        sent_q.delete();
        got_q.delete();
        exp_q.delete();
        exp_cnt = 0;

        // Continuous capture over three frames; CONT_I dropped during the third.
        CONT_I = 1'b1;
        step(2);
        for (int f = 0; f < 3; f++) begin
            int unsigned g;
            g = $urandom_range(3, 1);
            send_frame(W, W, int'(g), 1'b0, 1'b0, f == 2);
            model_frame(1000);
            if (f < 2) step(40);
        end
        wait_idle(300);
        compare_stream("t6");
        chk("t6_cnt", FRAME_CNT_O, 8'(exp_cnt));
        chk("t6_size", SIZE_ERR_O, 0);

        // No request pending: a frame on the bus must be ignored.
        send_frame(W, W, 1, 1'b0, 1'b0, 1'b0);
        sent_q.delete();
        step(10);
        chk("t7_no_bytes", got_q.size(), 0);
        chk("t7_cnt", FRAME_CNT_O, 8'(exp_cnt));
        chk("t7_busy", BUSY_O, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
